// File: rtl/conv_pkg.sv
// Shared fixed-point constants and helpers for the conv / pooling datapath.
// Q16.16 signed samples, 3x3 kernel taps in row-major order.
package conv_pkg;

  localparam int CONV_SIZE = 32;
  localparam int CONV_FRAC = 16;
  localparam int KERN_TAPS = 9;
  localparam int ACC_W     = 2*CONV_SIZE+4;

  localparam int K_TL = 0;
  localparam int K_TC = 1;
  localparam int K_TR = 2;
  localparam int K_ML = 3;
  localparam int K_MC = 4;
  localparam int K_MR = 5;
  localparam int K_BL = 6;
  localparam int K_BC = 7;
  localparam int K_BR = 8;

  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W-CONV_SIZE+1){1'b0}}, {(CONV_SIZE-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    {{(ACC_W-CONV_SIZE+1){1'b1}}, {(CONV_SIZE-1){1'b0}}};

  // Floor-shift a wide accumulator back to sample scale and clamp.
  function automatic logic signed [CONV_SIZE-1:0] sat_shift(
    input logic signed [ACC_W-1:0] acc,
    input int                      frac
  );
    logic signed [ACC_W-1:0] sh;
    sh = acc >>> frac;
    if (sh > SAT_MAX)
      return SAT_MAX[CONV_SIZE-1:0];
    else if (sh < SAT_MIN)
      return SAT_MIN[CONV_SIZE-1:0];
    else
      return sh[CONV_SIZE-1:0];
  endfunction

endpackage

// File: rtl/conv3x3_stream_line_buffer.sv
// One-row delay line: single write port, asynchronous read port.
// Read-before-write on the same address returns the previous row's pixel.
module line_buffer #(
  parameter int DEPTH = 300,
  parameter int WIDTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we)
      mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/conv3x3_stream.sv
// Streaming 3x3 Q16.16 convolution, valid-only windows, raster order.
// Window capture -> 9 products -> sum/shift/saturate.
module conv3x3_stream
  import conv_pkg::*;
#(
  parameter int IMG_W = 300,
  parameter int IMG_H = 300,
  parameter int SIZE  = CONV_SIZE,
  parameter int FRAC  = CONV_FRAC
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic [SIZE-1:0] in,
  input  logic            coef_we,
  input  logic [3:0]      coef_addr,
  input  logic [SIZE-1:0] coef_data,
  output logic [SIZE-1:0] out,
  output logic            out_valid,
  output logic            frame_done
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int PW = 2*SIZE;

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          col_end;
  logic          row_end;

  assign col_end = (col == CW'(IMG_W-1));
  assign row_end = (row == RW'(IMG_H-1));

  always_ff @(posedge clk) begin
    if (reset) begin
      col <= '0;
      row <= '0;
    end else if (load) begin
      if (col_end) begin
        col <= '0;
        row <= row_end ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  logic [SIZE-1:0] lb1_q;
  logic [SIZE-1:0] lb2_q;

  line_buffer #(
    .DEPTH (IMG_W),
    .WIDTH (SIZE)
  ) u_lb1 (
    .clk   (clk),
    .we    (load),
    .waddr (col),
    .wdata (in),
    .raddr (col),
    .rdata (lb1_q)
  );

  line_buffer #(
    .DEPTH (IMG_W),
    .WIDTH (SIZE)
  ) u_lb2 (
    .clk   (clk),
    .we    (load),
    .waddr (col),
    .wdata (lb1_q),
    .raddr (col),
    .rdata (lb2_q)
  );

  // win[0] is the oldest row, column 2 the newest column.
  logic signed [SIZE-1:0] win [3][3];
  logic                   win_vld;
  logic                   win_last;

  always_ff @(posedge clk) begin
    if (load) begin
      for (int r = 0; r < 3; r++) begin
        win[r][0] <= win[r][1];
        win[r][1] <= win[r][2];
      end
      win[0][2] <= lb2_q;
      win[1][2] <= lb1_q;
      win[2][2] <= in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      win_vld  <= 1'b0;
      win_last <= 1'b0;
    end else begin
      win_vld  <= load && (row >= RW'(2)) && (col >= CW'(2));
      win_last <= load && row_end && col_end;
    end
  end

  // Writes land one edge late so a window captured on the write edge
  // still multiplies against the old bank.
  logic signed [SIZE-1:0] coef [KERN_TAPS];
  logic                   pend_we;
  logic [3:0]             pend_addr;
  logic [SIZE-1:0]        pend_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_we   <= 1'b0;
      pend_addr <= '0;
      pend_data <= '0;
      for (int i = 0; i < KERN_TAPS; i++)
        coef[i] <= '0;
      coef[K_MC] <= SIZE'(1) << FRAC;
    end else begin
      pend_we   <= coef_we;
      pend_addr <= coef_addr;
      pend_data <= coef_data;
      if (pend_we && (pend_addr < 4'(KERN_TAPS)))
        coef[pend_addr] <= pend_data;
    end
  end

  logic signed [PW-1:0] prod [KERN_TAPS];
  logic                 p_vld;
  logic                 p_last;

  always_ff @(posedge clk) begin
    for (int i = 0; i < KERN_TAPS; i++)
      prod[i] <= PW'(win[i/3][i%3]) * PW'(coef[i]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      p_vld  <= 1'b0;
      p_last <= 1'b0;
    end else begin
      p_vld  <= win_vld;
      p_last <= win_last;
    end
  end

  logic signed [ACC_W-1:0] acc;

  always_comb begin
    acc = '0;
    for (int i = 0; i < KERN_TAPS; i++)
      acc = acc + ACC_W'(prod[i]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out        <= '0;
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      out_valid  <= p_vld;
      frame_done <= p_vld && p_last;
      if (p_vld)
        out <= sat_shift(acc, FRAC);
    end
  end

endmodule

// File: tb/tb_conv3x3_stream.sv
// Bench for conv3x3_stream on a 5x4 image: directed frames plus random
// traffic, all checked against a frame-array convolution model.
module tb_conv3x3_stream;

  localparam int W = 5;
  localparam int H = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        load = 1'b0;
  logic [31:0] in = '0;
  logic        coef_we = 1'b0;
  logic [3:0]  coef_addr = '0;
  logic [31:0] coef_data = '0;
  logic [31:0] out;
  logic        out_valid;
  logic        frame_done;

  conv3x3_stream #(
    .IMG_W (W),
    .IMG_H (H)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .in         (in),
    .coef_we    (coef_we),
    .coef_addr  (coef_addr),
    .coef_data  (coef_data),
    .out        (out),
    .out_valid  (out_valid),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] val;
    logic        last;
    int          due;
  } exp_t;

  exp_t               q[$];
  logic signed [31:0] mc [9];
  logic signed [31:0] img [H][W];
  int                 mrow, mcol, cyc;
  int                 checks = 0;
  int                 errors = 0;
  logic [31:0]        exp_out;
  logic [31:0]        got[$];
  bit                 got_fd[$];
  int                 first_cyc, acc12;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Plain 3x3 dot product over the stored frame, floor shift, clamp.
  function automatic logic [31:0] conv_at(int r, int c);
    logic signed [67:0] s;
    longint v;
    s = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        s += 68'(img[r-2+i][c-2+j]) * 68'(mc[i*3+j]);
    v = longint'(s >>> 16);
    if (v > 64'sh7FFFFFFF) return 32'h7FFFFFFF;
    if (v < -64'sh80000000) return 32'h80000000;
    return v[31:0];
  endfunction

  task automatic compare();
    bit ev, efd;
    ev  = (q.size() > 0) && (q[0].due == cyc);
    efd = 1'b0;
    if (ev) begin
      exp_out = q[0].val;
      efd     = q[0].last;
      void'(q.pop_front());
    end
    chk("out_valid", {31'b0, out_valid}, {31'b0, ev});
    chk("out", out, exp_out);
    chk("frame_done", {31'b0, frame_done}, {31'b0, efd});
    if (out_valid) begin
      if (got.size() == 0) first_cyc = cyc;
      got.push_back(out);
      got_fd.push_back(frame_done);
    end
  endtask

  task automatic step(input logic l, input logic [31:0] px,
                      input logic we, input logic [3:0] a,
                      input logic [31:0] d);
    reset = 1'b0; load = l; in = px;
    coef_we = we; coef_addr = a; coef_data = d;
    @(posedge clk);
    cyc++;
    if (l) begin
      img[mrow][mcol] = px;
      if (mrow >= 2 && mcol >= 2)
        q.push_back('{val: conv_at(mrow, mcol),
                      last: (mrow == H-1 && mcol == W-1),
                      due: cyc + 2});
      if (mcol == W-1) begin
        mcol = 0;
        mrow = (mrow == H-1) ? 0 : mrow + 1;
      end else begin
        mcol++;
      end
    end
    if (we && a < 9) mc[a] = d;
    @(negedge clk);
    compare();
  endtask

  task automatic do_reset();
    reset = 1'b1; load = 1'b0; coef_we = 1'b0;
    @(posedge clk);
    cyc++;
    q.delete();
    exp_out = '0;
    mrow = 0; mcol = 0;
    for (int i = 0; i < 9; i++) mc[i] = '0;
    mc[4] = 32'h00010000;
    @(negedge clk);
    compare();
    reset = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, '0, '0);
  endtask

  task automatic set_coefs(input logic [31:0] v, input logic [31:0] ctr);
    for (int i = 0; i < 9; i++)
      step(1'b0, '0, 1'b1, 4'(i), (i == 4) ? ctr : v);
  endtask

  task automatic feed(input logic [31:0] base, input logic [31:0] inc,
                      input int gap);
    for (int i = 0; i < W*H; i++) begin
      step(1'b1, base + inc * i, 1'b0, '0, '0);
      if (i == 12) acc12 = cyc;
      idle(gap);
    end
  endtask

  task automatic clear_log();
    got.delete();
    got_fd.delete();
    first_cyc = -1;
  endtask

  function automatic int fd_count();
    int n = 0;
    foreach (got_fd[i]) n += int'(got_fd[i]);
    return n;
  endfunction

  task automatic chk_ramp(input string nm, input int first, input int off);
    int ctr [6] = '{6, 7, 8, 11, 12, 13};
    for (int k = 0; k < 6; k++)
      chk(nm, (first + k < got.size()) ? got[first+k] : 32'hxxxxxxxx,
          32'(ctr[k] + off) << 16);
  endtask

  initial begin
    logic l, w;
    int   n;
    cyc = 0;
    exp_out = '0;
    mrow = 0; mcol = 0;
    do_reset();
    chk("reset_out", out, 32'h0);

    // identity kernel, ramp, load every cycle
    clear_log();
    feed(32'h0, 32'h00010000, 0);
    idle(4);
    chk("t1_count", got.size(), 6);
    chk_ramp("t1_val", 0, 0);
    chk("t1_latency", first_cyc, acc12 + 2);
    chk("t1_fd", fd_count(), 1);
    chk("t1_fd_last", {31'b0, got_fd[5]}, 1);

    // all-ones kernel
    set_coefs(32'h00010000, 32'h00010000);
    clear_log();
    feed(32'h00010000, 32'h0, 0);
    idle(4);
    chk("t2_count", got.size(), 6);
    chk("t2_nine", got[0], 32'h00090000);
    chk("t2_nine_end", got[5], 32'h00090000);
    // nine taps of 0.5 lsb give 4.5 lsb, floored to 4
    set_coefs(32'h00008000, 32'h00008000);
    clear_log();
    feed(32'h00000001, 32'h0, 0);
    idle(4);
    chk("t2_trunc_pos", got[2], 32'h00000004);
    // -4.5 lsb floors toward -inf to -5
    clear_log();
    feed(32'hFFFFFFFF, 32'h0, 0);
    idle(4);
    chk("t2_trunc_neg", got[3], 32'hFFFFFFFB);

    // saturation both ways
    set_coefs(32'h00010000, 32'h00010000);
    clear_log();
    feed(32'h7FFF0000, 32'h0, 0);
    idle(4);
    chk("t3_sat_hi", got[1], 32'h7FFFFFFF);
    clear_log();
    feed(32'h80000000, 32'h0, 0);
    idle(4);
    chk("t3_sat_lo", got[4], 32'h80000000);

    // identity, load every other cycle
    set_coefs(32'h0, 32'h00010000);
    clear_log();
    feed(32'h0, 32'h00010000, 1);
    idle(4);
    chk("t4_count", got.size(), 6);
    chk_ramp("t4_val", 0, 0);

    // two frames back to back
    clear_log();
    feed(32'h0, 32'h00010000, 0);
    feed(32'h00640000, 32'h00010000, 0);
    idle(4);
    chk("t5_count", got.size(), 12);
    chk("t5_fd", fd_count(), 2);
    chk("t5_fd1", {31'b0, got_fd[5]}, 1);
    chk("t5_fd2", {31'b0, got_fd[11]}, 1);
    chk_ramp("t5_f2", 6, 100);

    // reset mid-frame after pixel 13 with a non-identity kernel
    set_coefs(32'h00010000, 32'h00020000);
    for (int i = 0; i <= 13; i++)
      step(1'b1, 32'(i) << 16, 1'b0, '0, '0);
    do_reset();
    chk("t6_ov_after_rst", {31'b0, out_valid}, 0);
    clear_log();
    feed(32'h0, 32'h00010000, 0);
    idle(4);
    chk("t6_count", got.size(), 6);
    chk_ramp("t6_val", 0, 0);
    chk("t6_fd", fd_count(), 1);

    // random traffic with mid-frame coefficient writes
    for (int i = 0; i < 9; i++)
      step(1'b0, '0, 1'b1, 4'(i),
           32'($urandom_range(0, 32'h3FFFF)) - 32'h20000);
    for (int f = 0; f < 4; f++) begin
      n = 0;
      while (n < W*H) begin
        l = ($urandom_range(0, 3) != 0);
        w = ($urandom_range(0, 5) == 0);
        step(l,
             (f == 1) ? 32'($urandom)
                      : 32'($urandom_range(0, 32'h1FFFFF)) - 32'h100000,
             w, 4'($urandom_range(0, 15)),
             32'($urandom_range(0, 32'h3FFFF)) - 32'h20000);
        n += int'(l);
      end
    end
    idle(4);
    chk("final_queue_empty", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
